mips_load_store_unit: RTL and testbench
=======================================

// Module: mips_load_store_unit
// PURPOSE
//  Memory-access stage feeding the word-wide MIPS data memory (comb read, posedge write).
//  Accepts one load/store request at a time from the pipeline.
//  Performs byte/half/word addressing, sign/zero extension on loads, and read-modify-write
//  for sub-word stores. Returns a one-cycle response pulse to the pipeline.
// PARAMETERS
//  Data_Width           32  data word width; fixed at 32, 4 byte lanes
//  Addr_Width           32  byte-address width of req_addr
//  Data_Mem_Addr_Width  10  word-index width of the data memory
// PORTS
//  clk         in   1                    rising-edge clock
//  rst         in   1                    asynchronous, active-high reset
//  req_valid   in   1                    request present
//  req_ready   out  1                    LSU can accept; 1 only in IDLE and rst=0
//  req_we      in   1                    1=store, 0=load
//  req_size    in   2                    00=byte, 01=half, 10=word, 11=illegal (error)
//  req_signed  in   1                    loads only: 1=sign-extend, 0=zero-extend
//  req_addr    in   Addr_Width           byte address
//  req_wdata   in   Data_Width           store data, right-aligned (lane 0 = bits 7:0)
//  resp_valid  out  1                    one-cycle completion pulse
//  resp_rdata  out  Data_Width           load result, held until the next response
//  resp_err    out  1                    valid with resp_valid; misaligned/illegal/range
//  mem_we      out  1                    data memory write enable
//  mem_addr    out  Data_Mem_Addr_Width  word index = addr_q[Data_Mem_Addr_Width+1:2]
//  mem_wdata   out  Data_Width           write word to memory
//  mem_rdata   in   Data_Width           combinational read data from memory
// BEHAVIOUR
//  - Reset (async): state=IDLE, req_ready=0 while rst=1, resp_valid=0, resp_rdata=0,
//    resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, all capture regs=0.
//  - Handshake: accept on the rising edge where req_valid & req_ready. The LSU captures
//    we/size/signed/addr/wdata into *_q regs. Request inputs are ignored outside IDLE.
//  - Byte lanes are little-endian: lane = addr_q[1:0]. Half uses lanes {1,0} or {3,2}.
//  - Alignment: half needs addr[0]=0, word needs addr[1:0]=00. Size 11 is illegal.
//  - States: IDLE, ACCESS, MERGE_WR, RESP.
//    IDLE -> RESP on accept when misaligned/illegal: resp_err=1, no memory access.
//    IDLE -> ACCESS on every other accept.
//    ACCESS, load: resp_rdata <= lane extract of mem_rdata, extended per signed_q -> RESP.
//    ACCESS, word store: mem_we=1, mem_wdata=wdata_q -> RESP.
//    ACCESS, sub-word store: mem_we=0; merge_q <= mem_rdata with the selected lanes
//      replaced by wdata_q[7:0] or wdata_q[15:0] -> MERGE_WR.
//    MERGE_WR: mem_we=1, mem_wdata=merge_q -> RESP.
//    RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready returns the next cycle.
//  - mem_we is decoded from the registered state only, so no combinational path from req_*.
//    mem_addr is driven from addr_q in every non-IDLE state.
//  - Latency from accept edge to resp_valid high:
//    error 1 cycle; load or word store 2 cycles; sub-word store 3 cycles.
//    Throughput is one request per latency+1 cycles.
//  - resp_err=0 on every good response. resp_rdata is unchanged by stores and errors.
//  - Address bits above Data_Mem_Addr_Width+1 are ignored, so the index wraps modulo the
//    depth (unless the range check below is compiled in).
//  - Reset mid-operation: async rst forces IDLE and drops mem_we immediately.
//    No response is issued. A sub-word store aborted in ACCESS leaves memory unchanged.
// CONFIGURATION
//  MIPS_LSU_RANGE_CHECK_EN defined:
//    Any nonzero req_addr bit above Data_Mem_Addr_Width+1 is an error.
//    It is handled like a misalignment: IDLE -> RESP with resp_err=1, no access.
//  MIPS_LSU_RANGE_CHECK_EN undefined: upper address bits are silently dropped (wrap).
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10
//     -> mem word 4 = 0xDEADBEEF; resp_rdata=0xDEADBEEF, 2 cycles after accept.
//  2. With word 4 = 0xDEADBEEF: byte store 0x55 @0x11 -> word 4 = 0xDEAD55EF.
//     mem_we is high only in MERGE_WR; resp at 3 cycles.
//  3. Word 4 = 0x80FF7F01: signed byte load @0x12 -> 0xFFFFFFFF;
//     unsigned half @0x12 -> 0x000080FF; signed half @0x10 -> 0x00007F01.
//  4. Half load @0x13, word store @0x12, size=11
//     -> each gives resp_err=1 at 1 cycle; mem_we never high; resp_rdata unchanged.
//  5. Assert rst during MERGE_WR of a half store
//     -> mem_we falls immediately, no resp_valid, word unchanged, req_ready=1 after release.
//  6. Word load @(1<<(Data_Mem_Addr_Width+2))
//     -> RANGE_CHECK_EN: resp_err=1; otherwise data from word 0 (wrap).

Source files
------------

// File: rtl/mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : mips_load_store_unit
// Desc   : MIPS memory-access stage; byte/half/word loads with sign/zero
//          extension, sub-word stores via read-modify-write on a word memory.
//          Define MIPS_LSU_RANGE_CHECK_EN to flag out-of-range addresses.
// Rev    : 1.0  initial release
// ============================================================================
module mips_load_store_unit #(
   parameter int DATA_WIDTH          = 32,
   parameter int ADDR_WIDTH          = 32,
   parameter int DATA_MEM_ADDR_WIDTH = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_we_i,
   input  logic [1:0]                     req_size_i,
   input  logic                           req_signed_i,
   input  logic [ADDR_WIDTH-1:0]          req_addr_i,
   input  logic [DATA_WIDTH-1:0]          req_wdata_i,
   output logic                           resp_valid_o,
   output logic [DATA_WIDTH-1:0]          resp_rdata_o,
   output logic                           resp_err_o,
   output logic                           mem_we_o,
   output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]          mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

   localparam int         c_IDX_TOP   = DATA_MEM_ADDR_WIDTH + 1;
   localparam logic [1:0] c_SIZE_BYTE = 2'b00;
   localparam logic [1:0] c_SIZE_HALF = 2'b01;
   localparam logic [1:0] c_SIZE_WORD = 2'b10;
   localparam logic [1:0] c_SIZE_ILL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_MERGE_WR = 2'd2,
      S_RESP     = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q;
   logic                    signed_q;
   logic                    err_q;
   logic [1:0]              size_q;
   logic [c_IDX_TOP:0]      addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   merge_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic                    w_accept;
   logic                    w_misalign;
   logic                    w_range_err;
   logic                    w_bad;
   logic                    w_subword_st;
   logic [DATA_WIDTH-1:0]   w_shifted;
   logic [DATA_WIDTH-1:0]   w_load;
   logic [DATA_WIDTH-1:0]   w_merge;
   logic [3:0]              w_be;

   assign req_ready_o = (state_q == S_IDLE) && !rst;
   assign w_accept    = req_valid_i && req_ready_o;

   assign w_misalign = (req_size_i == c_SIZE_ILL)
                    || ((req_size_i == c_SIZE_HALF) && req_addr_i[0])
                    || ((req_size_i == c_SIZE_WORD) && (req_addr_i[1:0] != 2'b00));

`ifdef MIPS_LSU_RANGE_CHECK_EN
   assign w_range_err = |req_addr_i[ADDR_WIDTH-1:c_IDX_TOP+1];
`else
   // Upper address bits are dropped so the word index wraps modulo the depth.
   logic w_unused_upper;
   assign w_range_err    = 1'b0;
   assign w_unused_upper = ^req_addr_i[ADDR_WIDTH-1:c_IDX_TOP+1];
`endif

   assign w_bad        = w_misalign || w_range_err;
   assign w_subword_st = we_q && (size_q != c_SIZE_WORD);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (w_accept) state_d = w_bad ? S_RESP : S_ACCESS;
         S_ACCESS:   state_d = w_subword_st ? S_MERGE_WR : S_RESP;
         S_MERGE_WR: state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Lane 0 of the shifted word is the addressed byte (little-endian lanes).
   assign w_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      w_load = mem_rdata_i;
      case (size_q)
         c_SIZE_BYTE: w_load = {{24{signed_q & w_shifted[7]}},  w_shifted[7:0]};
         c_SIZE_HALF: w_load = {{16{signed_q & w_shifted[15]}}, w_shifted[15:0]};
         default:     w_load = mem_rdata_i;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_be[i] = (size_q == c_SIZE_BYTE) ? (addr_q[1:0] == 2'(i))
                                               : (addr_q[1] == 1'(i / 2));
      assign w_merge[8*i +: 8] = !w_be[i] ? mem_rdata_i[8*i +: 8]
                               : (size_q == c_SIZE_BYTE) ? wdata_q[7:0]
                                                         : wdata_q[8*(i%2) +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            addr_q   <= req_addr_i[c_IDX_TOP:0];
            wdata_q  <= req_wdata_i;
            err_q    <= w_bad;
         end
         if ((state_q == S_ACCESS) && !we_q) rdata_q <= w_load;
         if (state_q == S_ACCESS)            merge_q <= w_merge;
      end
   end

   // Write enable depends on registered state only; no path from req_* inputs.
   assign mem_we_o     = (state_q == S_MERGE_WR)
                      || ((state_q == S_ACCESS) && we_q && (size_q == c_SIZE_WORD));
   assign mem_addr_o   = addr_q[c_IDX_TOP:2];
   assign mem_wdata_o  = (state_q == S_MERGE_WR) ? merge_q
                       : (state_q == S_ACCESS)   ? wdata_q
                                                 : '0;
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_err_o   = (state_q == S_RESP) && err_q;
   assign resp_rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_load_store_unit
// Desc   : Directed self-checking bench for mips_load_store_unit with a
//          1024-word data memory (comb read, posedge write).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_signed_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        mem_we_o;
   logic [9:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   logic [31:0] mem [0:1023];
   logic        tb_we = 1'b0;
   logic [9:0]  tb_idx = '0;
   logic [31:0] tb_data = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int          lat;
   logic        err;
   logic [7:0]  wm;

   always #5 clk = ~clk;

   assign mem_rdata_i = mem[mem_addr_o];
   always @(posedge clk) begin
      if (mem_we_o)   mem[mem_addr_o] <= mem_wdata_o;
      else if (tb_we) mem[tb_idx]     <= tb_data;
   end

   mips_load_store_unit #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DATA_MEM_ADDR_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   task automatic preload(input logic [9:0] idx, input logic [31:0] data);
      tb_idx = idx; tb_data = data; tb_we = 1'b1;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   // Issues one request; returns latency (edges after accept), error flag and
   // a per-cycle mask of mem_we (bit c = cycle c after accept).
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int o_lat, output logic o_err, output logic [7:0] o_wm);
      int  n;
      bit  done;
      n = 0;
      while (!req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
      if (!req_ready_o) begin
         n_checks++; n_fail++;
         $display("FAIL ready_timeout: req_ready got %b required 1", req_ready_o);
      end
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_signed_i = sgn;
      req_addr_i = addr; req_wdata_i = wdata;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      o_lat = -1; o_err = 1'bx; o_wm = '0; done = 1'b0;
      for (int c = 1; c <= 6 && !done; c++) begin
         if (mem_we_o) o_wm[c] = 1'b1;
         n_checks++;
         if (req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: cycle %0d req_ready got %b required 0", c, req_ready_o);
         end
         if (resp_valid_o) begin
            o_lat = c; o_err = resp_err_o; done = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #3;
      n_checks++;
      if ({req_ready_o, resp_valid_o, resp_err_o, mem_we_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/valid/err/we got %b required 0000",
                  {req_ready_o, resp_valid_o, resp_err_o, mem_we_o});
      end
      n_checks++;
      if (resp_rdata_o !== 32'h0 || mem_addr_o !== 10'h0 || mem_wdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: rdata %h addr %h wdata %h required all 0",
                  resp_rdata_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b required 1", req_ready_o);
      end
   endtask

   task automatic test_word;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, wm);
      n_checks++;
      if (lat !== 2 || err !== 1'b0 || wm !== 8'b0000_0010) begin
         n_fail++;
         $display("FAIL word_store: lat %0d err %b we_mask %b required 2 0 00000010", lat, err, wm);
      end
      n_checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL word_store_mem: got %h required deadbeef", mem[4]);
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, wm);
      n_checks++;
      if (lat !== 2 || err !== 1'b0 || wm !== 8'h00 || resp_rdata_o !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL word_load: lat %0d err %b we_mask %b rdata %h required 2 0 0 deadbeef",
                  lat, err, wm, resp_rdata_o);
      end
   endtask

   task automatic test_subword_store;
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, err, wm);
      n_checks++;
      if (lat !== 3 || err !== 1'b0 || wm !== 8'b0000_0100) begin
         n_fail++;
         $display("FAIL byte_store: lat %0d err %b we_mask %b required 3 0 00000100", lat, err, wm);
      end
      n_checks++;
      if (mem[4] !== 32'hDEAD55EF || resp_rdata_o !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL byte_store_mem: mem %h rdata %h required dead55ef deadbeef",
                  mem[4], resp_rdata_o);
      end
      preload(10'd5, 32'h11223344);
      do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h5555CAFE, lat, err, wm);
      n_checks++;
      if (lat !== 3 || mem[5] !== 32'hCAFE3344) begin
         n_fail++;
         $display("FAIL half_store_hi: lat %0d mem %h required 3 cafe3344", lat, mem[5]);
      end
      do_req(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000BEEF, lat, err, wm);
      n_checks++;
      if (mem[5] !== 32'hCAFEBEEF) begin
         n_fail++; $display("FAIL half_store_lo: got %h required cafebeef", mem[5]);
      end
   endtask

   task automatic test_load_ext;
      preload(10'd4, 32'h80FF7F01);
      do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, err, wm);
      n_checks++;
      if (lat !== 2 || resp_rdata_o !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL lb_s_12: lat %0d rdata %h required 2 ffffffff", lat, resp_rdata_o);
      end
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'h000080FF) begin
         n_fail++; $display("FAIL lhu_12: got %h required 000080ff", resp_rdata_o);
      end
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'h00007F01) begin
         n_fail++; $display("FAIL lh_s_10: got %h required 00007f01", resp_rdata_o);
      end
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'hFFFFFF80) begin
         n_fail++; $display("FAIL lb_s_13: got %h required ffffff80", resp_rdata_o);
      end
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'h00000080) begin
         n_fail++; $display("FAIL lbu_13: got %h required 00000080", resp_rdata_o);
      end
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'hFFFF80FF) begin
         n_fail++; $display("FAIL lh_s_12: got %h required ffff80ff", resp_rdata_o);
      end
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, err, wm);
      n_checks++;
      if (resp_rdata_o !== 32'h0000007F) begin
         n_fail++; $display("FAIL lbu_11: got %h required 0000007f", resp_rdata_o);
      end
   endtask

   task automatic test_errors;
      preload(10'd4, 32'h13579BDF);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, wm);
      do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, lat, err, wm);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || wm !== 8'h00 || resp_rdata_o !== 32'h13579BDF) begin
         n_fail++;
         $display("FAIL err_half_misalign: lat %0d err %b we_mask %b rdata %h required 1 1 0 13579bdf",
                  lat, err, wm, resp_rdata_o);
      end
      do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, lat, err, wm);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || wm !== 8'h00 || mem[4] !== 32'h13579BDF) begin
         n_fail++;
         $display("FAIL err_word_misalign: lat %0d err %b we_mask %b mem %h required 1 1 0 13579bdf",
                  lat, err, wm, mem[4]);
      end
      do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, lat, err, wm);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || wm !== 8'h00 || resp_rdata_o !== 32'h13579BDF) begin
         n_fail++;
         $display("FAIL err_size11: lat %0d err %b we_mask %b rdata %h required 1 1 0 13579bdf",
                  lat, err, wm, resp_rdata_o);
      end
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err, wm);
      n_checks++;
      if (lat !== 2 || err !== 1'b0 || resp_rdata_o !== 32'h00000013) begin
         n_fail++;
         $display("FAIL good_after_err: lat %0d err %b rdata %h required 2 0 00000013",
                  lat, err, resp_rdata_o);
      end
   endtask

   task automatic test_reset_mid;
      bit saw_resp;
      preload(10'd6, 32'h01020304);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b01; req_signed_i = 1'b0;
      req_addr_i = 32'h18; req_wdata_i = 32'h0000BEEF;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      n_checks++;
      if (mem_we_o !== 1'b0) begin
         n_fail++; $display("FAIL rmid_access_we: got %b required 0", mem_we_o);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'h0102BEEF) begin
         n_fail++;
         $display("FAIL rmid_merge: we %b wdata %h required 1 0102beef", mem_we_o, mem_wdata_o);
      end
      rst = 1'b1; #1;
      n_checks++;
      if (mem_we_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_abort: we %b resp_valid %b required 0 0", mem_we_o, resp_valid_o);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem[6] !== 32'h01020304) begin
         n_fail++; $display("FAIL rmid_mem: got %h required 01020304", mem[6]);
      end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL rmid_ready: got %b required 1", req_ready_o);
      end
      saw_resp = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (resp_valid_o) saw_resp = 1'b1;
      end
      n_checks++;
      if (saw_resp !== 1'b0) begin
         n_fail++; $display("FAIL rmid_no_resp: resp seen %b required 0", saw_resp);
      end
   endtask

   task automatic test_wrap;
      preload(10'd0, 32'h0BADF00D);
      do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, err, wm);
      n_checks++;
`ifdef MIPS_LSU_RANGE_CHECK_EN
      if (lat !== 1 || err !== 1'b1) begin
         n_fail++; $display("FAIL range_err: lat %0d err %b required 1 1", lat, err);
      end
`else
      if (lat !== 2 || err !== 1'b0 || resp_rdata_o !== 32'h0BADF00D) begin
         n_fail++;
         $display("FAIL addr_wrap: lat %0d err %b rdata %h required 2 0 0badf00d",
                  lat, err, resp_rdata_o);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_store();
      test_load_ext();
      test_errors();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
